pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 170 +++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register between two processor stages.
//
// Carries a DATA_W payload plus a CTRL_W control bundle. A bubble (out_valid=0)
// always presents an all-zero control bundle so no downstream write can fire.
// out_data keeps its last loaded value while the stage is empty.
//
// Build option PIPE_SKID_BUF_EN:
//   undefined : single entry, in_ready = ~out_valid | out_ready (combinational)
//   defined   : head + skid entry, in_ready registered (no out_ready -> in_ready path)
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready upstream handshake, in_data/in_ctrl upstream entry
//   flush             squash held and incoming entries at the next edge
//   out_valid/out_ready downstream handshake, out_data/out_ctrl head entry
//   stall_cnt         saturating count of edges with out_valid & ~out_ready
//
// Skid-mode states:
//   state | meaning
//   EMPTY | no entry held
//   ONE   | head valid, skid empty
//   TWO   | head and skid valid, upstream blocked
module pipe_stage_reg #(
  parameter int DATA_W = 57,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              accept;
  logic              consume;
  logic [DATA_W-1:0] head_data_q;
  logic [CTRL_W-1:0] head_ctrl_q;

`ifdef PIPE_SKID_BUF_EN

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t            state_q, state_d;
  logic              in_ready_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic              load_head_in, load_head_skid, load_skid;

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = in_ready_q;
  assign accept    = in_valid & in_ready_q & ~flush;
  assign consume   = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = ONE;
            load_head_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && consume) begin
            load_head_in = 1'b1;
          end else if (accept) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only a consume can move things
          if (consume) begin
            state_d        = ONE;
            load_head_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      // registered ready decouples upstream timing from out_ready
      in_ready_q <= (state_d != TWO);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_data_q <= '0;
      head_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      if (load_head_in) begin
        head_data_q <= in_data;
        head_ctrl_q <= in_ctrl;
      end else if (load_head_skid) begin
        head_data_q <= skid_data_q;
        head_ctrl_q <= skid_ctrl_q;
      end
      if (load_skid) begin
        skid_data_q <= in_data;
        skid_ctrl_q <= in_ctrl;
      end
    end
  end

`else

  logic valid_q;

  assign out_valid = valid_q;
  assign in_ready  = ~valid_q | out_ready;
  assign accept    = in_valid & in_ready & ~flush;
  assign consume   = valid_q & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      head_data_q <= '0;
      head_ctrl_q <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q     <= 1'b1;
      head_data_q <= in_data;
      head_ctrl_q <= in_ctrl;
    end else if (consume) begin
      valid_q <= 1'b0;
    end
  end

`endif

  assign out_data = head_data_q;
  // stored ctrl survives a flush/consume, so gate it to force a clean bubble
  assign out_ctrl = out_valid ? head_ctrl_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed scenarios followed by random traffic,
// all checked against a queue model of the stage.
module tb_pipe_stage_reg;

  localparam int DW = 57;
  localparam int CW = 8;
`ifdef PIPE_SKID_BUF_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready, in_ready4;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          flush;
  logic          out_valid, out_valid4;
  logic          out_ready;
  logic [DW-1:0] out_data, out_data4;
  logic [CW-1:0] out_ctrl, out_ctrl4;
  logic [15:0]   stall_cnt;
  logic [3:0]    stall_cnt4;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] qd[$];
  logic [CW-1:0] qc[$];
  logic [DW-1:0] m_last;
  int            m_cnt;
  int            m_cnt4;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_ctrl(out_ctrl4), .stall_cnt(stall_cnt4)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_ready(input bit ordy);
    return (qd.size() < DEPTH) || (DEPTH == 1 && ordy);
  endfunction

  task automatic check_outs(input string tag);
    bit            mv;
    logic [DW-1:0] md;
    logic [CW-1:0] mc;
    mv = (qd.size() > 0);
    md = mv ? qd[0] : m_last;
    mc = mv ? qc[0] : '0;
    chk({tag, "_valid"}, 64'(out_valid), 64'(mv));
    chk({tag, "_data"},  64'(out_data),  64'(md));
    chk({tag, "_ctrl"},  64'(out_ctrl),  64'(mc));
    chk({tag, "_stall"}, 64'(stall_cnt), 64'(m_cnt));
    chk({tag, "_stall4"}, 64'(stall_cnt4), 64'(m_cnt4));
  endtask

  task automatic cycle(input bit iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input bit fl, input bit ordy);
    bit ir, acc, cons;
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    flush     = fl;
    out_ready = ordy;
    #1;
    ir = model_ready(ordy);
    chk("in_ready", 64'(in_ready), 64'(ir));
    acc  = iv && ir && !fl;
    cons = (qd.size() > 0) && ordy;
    @(posedge clk);
    if (qd.size() > 0 && !ordy) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (fl) begin
      qd.delete();
      qc.delete();
    end else begin
      if (cons) begin
        void'(qd.pop_front());
        void'(qc.pop_front());
      end
      if (acc) begin
        qd.push_back(d);
        qc.push_back(c);
      end
    end
    if (qd.size() > 0) m_last = qd[0];
    #1;
    check_outs("cyc");
    @(negedge clk);
  endtask

  task automatic model_reset();
    qd.delete();
    qc.delete();
    m_last = '0;
    m_cnt  = 0;
    m_cnt4 = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] r;
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_ctrl = '0; flush = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outs("reset");
    chk("reset_in_ready", 64'(in_ready), 64'(1));

    // streaming
    cycle(1'b1, DW'(1), 8'h01, 1'b0, 1'b1);
    chk("stream_d1", 64'(out_data), 64'(1));
    cycle(1'b1, DW'(2), 8'h02, 1'b0, 1'b1);
    chk("stream_d2", 64'(out_data), 64'(2));
    cycle(1'b1, DW'(3), 8'h03, 1'b0, 1'b1);
    chk("stream_d3", 64'(out_data), 64'(3));
    chk("stream_v3", 64'(out_valid), 64'(1));

    // stall 5 cycles
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'(10 + i), 8'h5A, 1'b0, 1'b0);
    chk("stall_cnt5", 64'(stall_cnt), 64'(5));
    chk("stall_hold", 64'(out_data), 64'(3));

    // flush with incoming entry
    cycle(1'b1, DW'(99), 8'h77, 1'b1, 1'b0);
    chk("flush_valid", 64'(out_valid), 64'(0));
    chk("flush_ctrl", 64'(out_ctrl), 64'(0));
    cycle(1'b0, DW'(0), 8'h00, 1'b0, 1'b1);
    chk("flush_discard", 64'(out_valid), 64'(0));

    // bubble after consume
    cycle(1'b1, DW'('h20), 8'hFF, 1'b0, 1'b1);
    chk("bubble_pre_ctrl", 64'(out_ctrl), 64'('hFF));
    cycle(1'b0, DW'(0), 8'h00, 1'b0, 1'b1);
    chk("bubble_valid", 64'(out_valid), 64'(0));
    chk("bubble_ctrl", 64'(out_ctrl), 64'(0));
    chk("bubble_data", 64'(out_data), 64'('h20));

    // saturation of the 4-bit counter
    cycle(1'b1, DW'('h30), 8'h11, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b0, DW'(0), 8'h00, 1'b0, 1'b0);
    chk("sat_cnt4", 64'(stall_cnt4), 64'('hF));
    cycle(1'b0, DW'(0), 8'h00, 1'b0, 1'b0);
    chk("sat_hold4", 64'(stall_cnt4), 64'('hF));

    // asynchronous reset mid-run while holding a valid entry
    rst = 1'b1;
    #1;
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_ctrl", 64'(out_ctrl), 64'(0));
    chk("arst_data", 64'(out_data), 64'(0));
    chk("arst_stall", 64'(stall_cnt), 64'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst_in_ready", 64'(in_ready), 64'(1));
    cycle(1'b0, DW'(0), 8'h00, 1'b0, 1'b1);
    chk("arst_no_partial", 64'(out_valid), 64'(0));

    // random traffic
    for (int i = 0; i < 600; i++) begin
      r = {$urandom, $urandom};
      cycle($urandom_range(0, 9) < 7, DW'(r), CW'($urandom),
            $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
